clr_ctrl: RTL and testbench

Issuer side of the domain-clear interface. On a single-cycle clear request from configuration logic, it drives the glitch-free `sys_clr` pulse that the reset synchronizer turns into per-domain stretched resets. It then watches the core, sample, SDRAM-data and USB domain resets assert and release, and reports completion or timeout. It runs on `core_clk` and is reset only by the system reset, never by `sys_clr`, so it survives the clear it generates.

---
 rtl/clr_ctrl.sv | 170 +++++++++++++++++
 tb/tb_clr_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clr_ctrl.sv
// clr_ctrl: issuer side of the domain-clear interface.
// A one-cycle clr_req starts a sequence. The block drives a registered sys_clr
// pulse that is CLR_CYCLES cycles long. It then waits until every tracked
// domain reset has asserted, and then until each of them has released. The
// sequence ends with a clr_done pulse or, on timeout, with sticky clr_err and
// clr_err_dom. Only sys_rst_ resets this block, so it survives the clear it
// issues.
module clr_ctrl #(
  parameter int CLR_CYCLES  = 8,   // sys_clr high time in core cycles, 2..255
  parameter int TO_W        = 16,  // timeout counter width
  parameter int SYNC_STAGES = 2    // synchronizer depth, at least 2
) (
  input  logic       core_clk,
  input  logic       sys_rst_,
  input  logic       clr_req,
  input  logic [3:0] dom_mask,
  input  logic       core_rst,
  input  logic       sample_rst,
  input  logic       sd_rst,
  input  logic       usb_rst,
  output logic       sys_clr,
  output logic       clr_busy,
  output logic       clr_done,
  output logic       clr_err,
  output logic [3:0] clr_err_dom
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSERT   = 3'd1,
    WAIT_SET = 3'd2,
    WAIT_REL = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  // Last value of the wait-state timeout counter. Reaching it while the exit
  // condition is still false means the wait has expired.
  localparam logic [TO_W-1:0] TO_MAX = '1;

  state_t          state_reg;
  logic [7:0]      cnt_reg;        // remaining ASSERT cycles
  logic [TO_W-1:0] to_cnt_reg;     // cycles spent in the current wait state
  logic [3:0]      m_reg;          // domain mask captured at request time
  logic [3:0]      err_dom_reg;    // unmet domains captured at expiry

  // Domain reset status seen by the FSM. Bit 0 is core, 1 sample, 2 sd, 3 usb.
  logic [2:0] async_rst;
  logic [2:0] rs_sync;
  logic [3:0] rs;
  logic       all_set;
  logic       all_clr;

  assign async_rst = {usb_rst, sd_rst, sample_rst};

  // Each asynchronous domain reset gets its own multi-flop synchronizer.
  // core_rst is already in core_clk and bypasses this.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      // Shift the asynchronous reset level through the synchronizer chain.
      always_ff @(posedge core_clk or negedge sys_rst_) begin
        if (!sys_rst_) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_rst[gi]};
        end
      end

      assign rs_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign rs = {rs_sync, core_rst};

  // Untracked domains count as already set and already released. This makes
  // an all-zero mask pass through both wait states in one cycle each.
  assign all_set = &(rs | ~m_reg);
  assign all_clr = ~|(rs & m_reg);

  // Sequencer. Every output is a flop, so sys_clr cannot glitch between edges.
  always_ff @(posedge core_clk or negedge sys_rst_) begin
    if (!sys_rst_) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      to_cnt_reg  <= '0;
      m_reg       <= '0;
      err_dom_reg <= '0;
      sys_clr     <= 1'b0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      clr_err     <= 1'b0;
      clr_err_dom <= '0;
    end else begin
      // clr_done is high only in the cycle spent in DONE.
      clr_done <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (clr_req) begin
            m_reg       <= dom_mask;
            clr_err     <= 1'b0;
            clr_err_dom <= '0;
            cnt_reg     <= 8'(CLR_CYCLES - 1);
            sys_clr     <= 1'b1;
            clr_busy    <= 1'b1;
            state_reg   <= ASSERT;
          end
        end

        ASSERT: begin
          if (cnt_reg == 8'd0) begin
            sys_clr    <= 1'b0;
            to_cnt_reg <= '0;
            state_reg  <= WAIT_SET;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        WAIT_SET: begin
          // Reaching the exit condition wins over a timeout in the same cycle.
          if (all_set) begin
            to_cnt_reg <= '0;
            state_reg  <= WAIT_REL;
          end else if (to_cnt_reg == TO_MAX) begin
            err_dom_reg <= m_reg & ~rs;
            clr_busy    <= 1'b0;
            state_reg   <= ERR;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

        WAIT_REL: begin
          if (all_clr) begin
            clr_done  <= 1'b1;
            state_reg <= DONE;
          end else if (to_cnt_reg == TO_MAX) begin
            err_dom_reg <= m_reg & rs;
            clr_busy    <= 1'b0;
            state_reg   <= ERR;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

        DONE: begin
          clr_busy  <= 1'b0;
          state_reg <= IDLE;
        end

        ERR: begin
          clr_err     <= 1'b1;
          clr_err_dom <= err_dom_reg;
          state_reg   <= IDLE;
        end

        default: begin
          sys_clr   <= 1'b0;
          clr_busy  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clr_ctrl.sv
// tb_clr_ctrl: self-checking bench for clr_ctrl.
// Behavioural domain-reset models assert on sys_clr and release a fixed number
// of their own clocks after it falls. The sample clock can be stopped.
// Expected outcomes go into a queue when a request is driven. They are checked
// against clr_done or a rising clr_err.
module tb_clr_ctrl;

  localparam int CLR_CYCLES  = 8;
  localparam int TO_W        = 8;
  localparam int SYNC_STAGES = 2;

  logic       core_clk;
  logic       sys_rst_;
  logic       clr_req;
  logic [3:0] dom_mask;
  logic       core_rst   = 1'b0;
  logic       sample_rst = 1'b0;
  logic       sd_rst     = 1'b0;
  logic       usb_rst    = 1'b0;
  logic       sys_clr;
  logic       clr_busy;
  logic       clr_done;
  logic       clr_err;
  logic [3:0] clr_err_dom;

  clr_ctrl #(
    .CLR_CYCLES (CLR_CYCLES),
    .TO_W       (TO_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .core_clk   (core_clk),
    .sys_rst_   (sys_rst_),
    .clr_req    (clr_req),
    .dom_mask   (dom_mask),
    .core_rst   (core_rst),
    .sample_rst (sample_rst),
    .sd_rst     (sd_rst),
    .usb_rst    (usb_rst),
    .sys_clr    (sys_clr),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .clr_err    (clr_err),
    .clr_err_dom(clr_err_dom)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // The sample clock equals core_clk, but the bench can stop it.
  logic sample_run = 1'b1;
  logic sample_clk;
  assign sample_clk = core_clk & sample_run;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Domain reset models. Each asserts asynchronously when sys_clr rises and
  // releases N+1 of its own clock edges after sys_clr is seen low.
  logic [7:0] core_cnt = '0, sample_cnt = '0, sd_cnt = '0, usb_cnt = '0;

  always @(posedge core_clk or posedge sys_clr)
    if (sys_clr) begin core_rst <= 1'b1; core_cnt <= 8'd2; end
    else if (core_cnt != 0) core_cnt <= core_cnt - 8'd1;
    else core_rst <= 1'b0;

  always @(posedge sample_clk or posedge sys_clr)
    if (sys_clr) begin sample_rst <= 1'b1; sample_cnt <= 8'd17; end
    else if (sample_cnt != 0) sample_cnt <= sample_cnt - 8'd1;
    else sample_rst <= 1'b0;

  always @(posedge core_clk or posedge sys_clr)
    if (sys_clr) begin sd_rst <= 1'b1; sd_cnt <= 8'd5; end
    else if (sd_cnt != 0) sd_cnt <= sd_cnt - 8'd1;
    else sd_rst <= 1'b0;

  always @(posedge core_clk or posedge sys_clr)
    if (sys_clr) begin usb_rst <= 1'b1; usb_cnt <= 8'd9; end
    else if (usb_cnt != 0) usb_cnt <= usb_cnt - 8'd1;
    else usb_rst <= 1'b0;

  // Cycle counter. The value seen at a negedge is the current cycle number.
  int  cyc = 0;
  time t_edge = 0;
  always @(posedge core_clk) begin
    cyc++;
    t_edge = $time;
  end

  // Scoreboard of expected sequence outcomes.
  typedef struct packed {
    logic       is_err;
    logic [3:0] dom;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic void push_exp(input logic is_err, input logic [3:0] dom);
    exp_t e;
    e.is_err = is_err;
    e.dom    = dom;
    sb.push_back(e);
  endfunction

  int   done_cnt  = 0;
  int   pulse_cnt = 0;
  int   end_cyc   = -1;
  int   hw        = 0;
  logic err_prev  = 1'b0;
  logic clr_prev  = 1'b0;

  // Outcome monitor and sys_clr pulse-width monitor, sampled on the falling edge.
  always @(negedge core_clk) begin
    if (!sys_rst_) begin
      hw = 0;
    end else begin
      if (clr_done) begin
        done_cnt++;
        end_cyc = cyc;
        $display("TXN cyc=%0d done", cyc);
        chk("sb_pending_done", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_kind_done", 32'(mon_e.is_err), 0);
        end
      end
      if (clr_err && !err_prev) begin
        end_cyc = cyc - 1;
        $display("TXN cyc=%0d err dom=%b", cyc, clr_err_dom);
        chk("sb_pending_err", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_kind_err", 32'(mon_e.is_err), 1);
          chk("sb_err_dom", clr_err_dom, mon_e.dom);
        end
      end
      if (sys_clr && !clr_prev) pulse_cnt++;
      if (sys_clr) hw++;
      else if (hw != 0) begin
        chk("clr_width", hw, CLR_CYCLES);
        hw = 0;
      end
    end
    err_prev = clr_err;
    clr_prev = sys_clr;
  end

  // While not in reset, sys_clr may only change right after a core_clk rising edge.
  always @(sys_clr)
    if (sys_rst_) chk("clr_on_edge", ($time == t_edge), 1);

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge core_clk);
      if (clr_done) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  int rel_c, done_c, p0, d0, acc;
  logic prev_s;

  initial begin
    sys_rst_ = 1'b0;
    clr_req  = 1'b0;
    dom_mask = 4'h0;
    repeat (3) @(negedge core_clk);
    chk("rst_outs", {sys_clr, clr_busy, clr_done, clr_err, clr_err_dom}, 0);
    sys_rst_ = 1'b1;
    repeat (3) @(negedge core_clk);

    // dom_mask = 0: minimum-length sequence.
    @(negedge core_clk);
    clr_req = 1'b1; dom_mask = 4'h0; push_exp(1'b0, 4'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge core_clk);
      clr_req = 1'b0;
      chk($sformatf("m0_sys_clr_c%0d", c), sys_clr, (c <= CLR_CYCLES));
      chk($sformatf("m0_busy_c%0d", c), clr_busy, (c <= CLR_CYCLES + 3));
      chk($sformatf("m0_done_c%0d", c), clr_done, (c == CLR_CYCLES + 3));
    end
    repeat (40) @(negedge core_clk);

    // Nominal run with all domains tracked. The sample reset releases last.
    @(negedge core_clk);
    clr_req = 1'b1; dom_mask = 4'hF; push_exp(1'b0, 4'h0);
    for (int c = 1; c <= CLR_CYCLES + 1; c++) begin
      @(negedge core_clk);
      clr_req = 1'b0;
      chk($sformatf("nom_sys_clr_c%0d", c), sys_clr, (c <= CLR_CYCLES));
      chk($sformatf("nom_busy_c%0d", c), clr_busy, 1);
    end
    rel_c = -1; done_c = -1; prev_s = sample_rst;
    for (int i = 0; i < 80 && done_c < 0; i++) begin
      @(negedge core_clk);
      if (prev_s && !sample_rst) rel_c = cyc;
      prev_s = sample_rst;
      if (clr_done) done_c = cyc;
    end
    chk("nom_done_seen", (done_c >= 0 && rel_c >= 0), 1);
    chk("nom_done_lat", done_c - rel_c, SYNC_STAGES + 1);
    chk("nom_err", clr_err, 0);
    repeat (40) @(negedge core_clk);

    // The sample clock is stopped, so the sample reset never releases and WAIT_REL times out.
    sample_run = 1'b0;
    @(negedge core_clk);
    clr_req = 1'b1; dom_mask = 4'hF; push_exp(1'b1, 4'b0010);
    for (int c = 1; c <= 268; c++) begin
      @(negedge core_clk);
      clr_req = 1'b0;
      if (c == 265) chk("to_busy_265", clr_busy, 1);
      if (c == 266) begin
        chk("to_busy_266", clr_busy, 0);
        chk("to_err_266", clr_err, 0);
      end
      if (c == 267) begin
        chk("to_err_267", clr_err, 1);
        chk("to_dom_267", clr_err_dom, 4'b0010);
        chk("to_busy_267", clr_busy, 0);
      end
    end
    // Re-request without the sample domain. The sticky error clears in cycle 1.
    clr_req = 1'b1; dom_mask = 4'b1101; push_exp(1'b0, 4'h0);
    @(negedge core_clk);
    clr_req = 1'b0;
    chk("rereq_err_c1", clr_err, 0);
    chk("rereq_dom_c1", clr_err_dom, 0);
    chk("rereq_busy_c1", clr_busy, 1);
    wait_done("rereq_done_seen", 100);
    sample_run = 1'b1;
    repeat (40) @(negedge core_clk);

    // Requests in cycles 3 and 12 arrive mid-sequence and must be ignored.
    p0 = pulse_cnt; d0 = done_cnt;
    for (int c = 0; c <= 80; c++) begin
      @(negedge core_clk);
      clr_req  = (c == 0 || c == 3 || c == 12);
      dom_mask = 4'hF;
      if (c == 0) push_exp(1'b0, 4'h0);
    end
    clr_req = 1'b0;
    chk("multi_pulses", pulse_cnt - p0, 1);
    chk("multi_dones", done_cnt - d0, 1);
    repeat (10) @(negedge core_clk);

    // Asynchronous reset in cycle 5 of ASSERT.
    d0 = done_cnt;
    @(negedge core_clk);
    clr_req = 1'b1; dom_mask = 4'hF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge core_clk);
      clr_req = 1'b0;
    end
    chk("arst_pre_clr", sys_clr, 1);
    #1 sys_rst_ = 1'b0;
    #1;
    chk("arst_clr", sys_clr, 0);
    chk("arst_busy", clr_busy, 0);
    repeat (2) @(negedge core_clk);
    sys_rst_ = 1'b1;
    repeat (30) @(negedge core_clk);
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_idle", {sys_clr, clr_busy, clr_err}, 0);

    // Random requests and mask toggling. A request is expected to be accepted
    // only when no sequence is outstanding and the previous one has ended.
    p0 = pulse_cnt; acc = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge core_clk);
      #1;
      dom_mask = 4'($urandom_range(0, 15));
      clr_req  = ($urandom_range(0, 19) == 0);
      if (clr_req && sb.size() == 0 && cyc > end_cyc) begin
        push_exp(1'b0, 4'h0);
        acc++;
      end
    end
    @(negedge core_clk);
    #1 clr_req = 1'b0;
    repeat (80) @(negedge core_clk);
    chk("rand_pulses", pulse_cnt - p0, acc);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
